stack_ctrl: RTL and testbench

STACK_CTRL -- requirements
Module: stack_ctrl

---
 rtl/stack_pkg.sv | 26 ++
 rtl/stack_ctrl_if.sv | 46 ++++
 rtl/stack_ptr.sv | 47 ++++
 rtl/stack_ctrl.sv | 159 +++++++++++++++
 tb/tb_stack_ctrl.sv | 253 +++++++++++++++++++++++++
 5 files changed

// File: rtl/stack_pkg.sv
// Shared encodings for the hardware stack controller: op codes, FSM states, SP reset value.
package stack_pkg;

  localparam int unsigned OP_W = 3;
  localparam int unsigned ST_W = 3;

  typedef logic [OP_W-1:0] op_t;
  typedef logic [ST_W-1:0] state_t;

  localparam op_t OP_NONE = 3'd0;
  localparam op_t OP_PUSH = 3'd1;
  localparam op_t OP_POP  = 3'd2;
  localparam op_t OP_CALL = 3'd3;
  localparam op_t OP_RET  = 3'd4;
  localparam op_t OP_INT  = 3'd5;
  localparam op_t OP_RTI  = 3'd6;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_POP_RD = 3'd1;
  localparam state_t S_INT_F  = 3'd2;
  localparam state_t S_RTI_F  = 3'd3;
  localparam state_t S_RTI_P  = 3'd4;

  localparam logic [7:0] SP_RESET = 8'hFF;

endpackage

// File: rtl/stack_ctrl_if.sv
// Request, memory and writeback bundle between the EX stage / stack memory and stack_ctrl.
interface stack_ctrl_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned FLAG_W = 4
);
  import stack_pkg::*;

  logic              op_valid;
  op_t               op_code;
  logic [DATA_W-1:0] wr_data;
  logic [DATA_W-1:0] ret_pc;
  logic [FLAG_W-1:0] flags_in;
  logic              sp_load;
  logic [DATA_W-1:0] sp_load_val;

  logic [DATA_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;
  logic              done;
  logic [DATA_W-1:0] pop_data;
  logic              pc_load;
  logic [DATA_W-1:0] pc_target;
  logic              flags_load;
  logic [FLAG_W-1:0] flags_out;
  logic              sp_wb_en;
  logic [DATA_W-1:0] sp_out;
  logic              err_ovf;
  logic              err_unf;

  modport master (
    output op_valid, op_code, wr_data, ret_pc, flags_in, sp_load, sp_load_val, mem_rdata,
    input  mem_addr, mem_wdata, mem_we, mem_re, busy, done, pop_data, pc_load, pc_target,
           flags_load, flags_out, sp_wb_en, sp_out, err_ovf, err_unf
  );

  modport slave (
    input  op_valid, op_code, wr_data, ret_pc, flags_in, sp_load, sp_load_val, mem_rdata,
    output mem_addr, mem_wdata, mem_we, mem_re, busy, done, pop_data, pc_load, pc_target,
           flags_load, flags_out, sp_wb_en, sp_out, err_ovf, err_unf
  );

endinterface

// File: rtl/stack_ptr.sv
// Stack pointer register with load/inc/dec; STACK_GUARD_EN enables full/empty blocking flags.
module stack_ptr
  import stack_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic [DATA_W-1:0] load_val_i,
  input  logic              inc_i,
  input  logic              dec_i,
  output logic [DATA_W-1:0] sp_cur_c_o,
  output logic [DATA_W-1:0] sp_nxt_c_o,
  output logic              sp_we_c_o,
  output logic              push_blk_c_o,
  output logic              pop_blk_c_o
);

  localparam logic [DATA_W-1:0] RST_VAL = DATA_W'(SP_RESET);

  logic [DATA_W-1:0] sp_q;

  // A same-cycle load becomes the SP the current op works from.
  assign sp_cur_c_o = load_i ? load_val_i : sp_q;
  assign sp_we_c_o  = load_i | inc_i | dec_i;

  always_comb begin
    sp_nxt_c_o = sp_cur_c_o;
    if (inc_i)      sp_nxt_c_o = sp_cur_c_o + DATA_W'(1);
    else if (dec_i) sp_nxt_c_o = sp_cur_c_o - DATA_W'(1);
  end

`ifdef STACK_GUARD_EN
  assign push_blk_c_o = (sp_cur_c_o == '0);
  assign pop_blk_c_o  = (sp_cur_c_o == RST_VAL);
`else
  assign push_blk_c_o = 1'b0;
  assign pop_blk_c_o  = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)         sp_q <= RST_VAL;
    else if (sp_we_c_o) sp_q <= sp_nxt_c_o;
  end

endmodule

// File: rtl/stack_ctrl.sv
// Hardware stack sequencer for PUSH/POP/CALL/RET/INT/RTI; guard behaviour set by STACK_GUARD_EN.
module stack_ctrl
  import stack_pkg::*;
#(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned FLAG_W = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  stack_ctrl_if.slave bus
);

  state_t            state_q, state_d;
  logic              ret_q, ret_d;
  logic              rd_blk_q, rd_blk_d;
  logic [DATA_W-1:0] pop_q, pop_d, pc_q, pc_d;
  logic [FLAG_W-1:0] flg_q, flg_d;
  logic              ovf_q, unf_q, ovf_set, unf_set;

  logic              push_req, pop_req, push_ok, pop_ok;
  logic [DATA_W-1:0] wdata_sel;
  logic              busy_c, done_c, pc_load_c, flags_load_c;
  logic              sp_load_en;
  logic [DATA_W-1:0] sp_cur, sp_nxt;
  logic              sp_we, push_blk, pop_blk;

  assign sp_load_en = bus.sp_load & (state_q == S_IDLE);

  stack_ptr #(.DATA_W(DATA_W)) u_sp (
    .clk          (clk),
    .rst_n        (rst_n),
    .load_i       (sp_load_en),
    .load_val_i   (bus.sp_load_val),
    .inc_i        (pop_ok),
    .dec_i        (push_ok),
    .sp_cur_c_o   (sp_cur),
    .sp_nxt_c_o   (sp_nxt),
    .sp_we_c_o    (sp_we),
    .push_blk_c_o (push_blk),
    .pop_blk_c_o  (pop_blk)
  );

  // Sequencer: decides which stack access happens this cycle and what completes.
  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    pop_d        = pop_q;
    pc_d         = pc_q;
    flg_d        = flg_q;
    push_req     = 1'b0;
    pop_req      = 1'b0;
    wdata_sel    = '0;
    busy_c       = 1'b0;
    done_c       = 1'b0;
    pc_load_c    = 1'b0;
    flags_load_c = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.op_valid) begin
          case (bus.op_code)
            OP_PUSH: begin push_req = 1'b1; wdata_sel = bus.wr_data; done_c = 1'b1; end
            OP_CALL: begin push_req = 1'b1; wdata_sel = bus.ret_pc;  done_c = 1'b1; end
            OP_POP, OP_RET: begin
              pop_req = 1'b1;
              busy_c  = 1'b1;
              ret_d   = (bus.op_code == OP_RET);
              state_d = S_POP_RD;
            end
            OP_INT: begin
              push_req  = 1'b1;
              wdata_sel = bus.ret_pc;
              busy_c    = 1'b1;
              state_d   = S_INT_F;
            end
            OP_RTI: begin pop_req = 1'b1; busy_c = 1'b1; state_d = S_RTI_F; end
            default: ;
          endcase
        end
      end
      S_POP_RD: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
        if (ret_q) begin
          if (!rd_blk_q) begin pc_load_c = 1'b1; pc_d = bus.mem_rdata; end
        end else begin
          pop_d = rd_blk_q ? '0 : bus.mem_rdata;
        end
      end
      S_INT_F: begin
        push_req  = 1'b1;
        wdata_sel = DATA_W'(bus.flags_in);
        done_c    = 1'b1;
        state_d   = S_IDLE;
      end
      S_RTI_F: begin
        busy_c  = 1'b1;
        pop_req = 1'b1;
        state_d = S_RTI_P;
        if (!rd_blk_q) begin flags_load_c = 1'b1; flg_d = bus.mem_rdata[FLAG_W-1:0]; end
      end
      S_RTI_P: begin
        done_c  = 1'b1;
        state_d = S_IDLE;
        if (!rd_blk_q) begin pc_load_c = 1'b1; pc_d = bus.mem_rdata; end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Memory port; a blocked read is remembered so its data phase is discarded.
  always_comb begin
    push_ok       = push_req & ~push_blk;
    pop_ok        = pop_req & ~pop_blk;
    ovf_set       = push_req & push_blk;
    unf_set       = pop_req & pop_blk;
    rd_blk_d      = pop_req ? pop_blk : rd_blk_q;
    bus.mem_we    = push_ok;
    bus.mem_re    = pop_ok;
    bus.mem_wdata = push_ok ? wdata_sel : '0;
    if (push_req)     bus.mem_addr = sp_cur;
    else if (pop_req) bus.mem_addr = sp_cur + DATA_W'(1);
    else              bus.mem_addr = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      ret_q    <= 1'b0;
      rd_blk_q <= 1'b0;
      pop_q    <= '0;
      pc_q     <= '0;
      flg_q    <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      ret_q    <= ret_d;
      rd_blk_q <= rd_blk_d;
      pop_q    <= pop_d;
      pc_q     <= pc_d;
      flg_q    <= flg_d;
      ovf_q    <= ovf_q | ovf_set;
      unf_q    <= unf_q | unf_set;
    end
  end

  assign bus.busy       = busy_c;
  assign bus.done       = done_c;
  assign bus.pop_data   = pop_d;
  assign bus.pc_load    = pc_load_c;
  assign bus.pc_target  = pc_d;
  assign bus.flags_load = flags_load_c;
  assign bus.flags_out  = flg_d;
  assign bus.sp_wb_en   = sp_we;
  assign bus.sp_out     = sp_nxt;
  assign bus.err_ovf    = ovf_q;
  assign bus.err_unf    = unf_q;

endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a stack model feeding write/read scoreboards.
module tb_stack_ctrl;
  import stack_pkg::*;

`ifdef STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stack_ctrl_if #(.DATA_W(8), .FLAG_W(4)) bus ();
  stack_ctrl #(.DATA_W(8), .FLAG_W(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  // Stack memory attached to the DUT: registered read, one-cycle latency.
  logic [7:0] mem [256];
  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    if (bus.mem_re) bus.mem_rdata <= mem[bus.mem_addr];
  end

  int checks = 0;
  int errors = 0;

  logic [7:0]  sp_m;
  logic [7:0]  mm [256];
  logic        ovf_m, unf_m;
  logic [15:0] exp_wr [$];
  logic [7:0]  exp_rd [$];
  op_t         cur_op = OP_NONE;
  logic        wb0;
  logic [7:0]  spo0;
  int          busy_n;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard consumers: every write / read-completion must match the next expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (bus.mem_we) begin
        if (exp_wr.size() == 0) chk("unexpected_write", 32'(exp_wr.size()), 1);
        else begin
          logic [15:0] w;
          w = exp_wr.pop_front();
          chk("wr_addr", bus.mem_addr, w[15:8]);
          chk("wr_data", bus.mem_wdata, w[7:0]);
        end
      end
      if (bus.flags_load) begin
        if (exp_rd.size() == 0) chk("unexpected_flags_load", 32'(exp_rd.size()), 1);
        else chk("flags_out", bus.flags_out, exp_rd.pop_front());
      end
      if (bus.pc_load) begin
        if (exp_rd.size() == 0) chk("unexpected_pc_load", 32'(exp_rd.size()), 1);
        else chk("pc_target", bus.pc_target, exp_rd.pop_front());
      end
      if (bus.done && cur_op == OP_POP) begin
        if (exp_rd.size() == 0) chk("unexpected_pop", 32'(exp_rd.size()), 1);
        else chk("pop_data", bus.pop_data, exp_rd.pop_front());
      end
    end
  end

  task automatic m_push(input logic [7:0] d);
    if (GUARD && sp_m == 8'h00) ovf_m = 1'b1;
    else begin
      exp_wr.push_back({sp_m, d});
      mm[sp_m] = d;
      sp_m = sp_m - 8'd1;
    end
  endtask

  task automatic m_pop(output logic [7:0] d, output logic blk);
    blk = GUARD && sp_m == 8'hFF;
    if (blk) begin unf_m = 1'b1; d = 8'h00; end
    else begin sp_m = sp_m + 8'd1; d = mm[sp_m]; end
  endtask

  task automatic issue(input op_t op, input logic [7:0] wd, input logic [7:0] rpc,
                       input logic [3:0] fl, input logic ld, input logic [7:0] ldv,
                       input int exp_lat, input string tag);
    int   lat;
    logic seen;
    @(posedge clk); #1;
    cur_op = op;
    bus.op_valid = 1'b1; bus.op_code = op; bus.wr_data = wd; bus.ret_pc = rpc;
    bus.flags_in = fl; bus.sp_load = ld; bus.sp_load_val = ldv;
    lat = 0; seen = 1'b0; busy_n = 0;
    while (!seen && lat < 8) begin
      @(negedge clk);
      if (lat == 0) begin wb0 = bus.sp_wb_en; spo0 = bus.sp_out; end
      if (bus.busy) busy_n++;
      lat++;
      seen = bus.done;
    end
    @(posedge clk); #1;
    bus.op_valid = 1'b0; bus.op_code = OP_NONE; bus.sp_load = 1'b0;
    chk({tag, "_done"}, 32'(seen), 1);
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_busy_cycles"}, busy_n, exp_lat - 1);
    chk({tag, "_wr_pending"}, 32'(exp_wr.size()), 0);
    chk({tag, "_rd_pending"}, 32'(exp_rd.size()), 0);
    @(negedge clk);
    chk({tag, "_sp"}, bus.sp_out, sp_m);
  endtask

  task automatic do_push(input logic [7:0] d, input logic ld, input logic [7:0] ldv, input string tag);
    if (ld) sp_m = ldv;
    m_push(d);
    issue(OP_PUSH, d, 8'h00, 4'h0, ld, ldv, 1, tag);
  endtask

  task automatic do_pop(input string tag);
    logic [7:0] d; logic b;
    m_pop(d, b);
    exp_rd.push_back(d);
    issue(OP_POP, 8'h00, 8'h00, 4'h0, 1'b0, 8'h00, 2, tag);
  endtask

  task automatic do_call(input logic [7:0] rpc, input string tag);
    m_push(rpc);
    issue(OP_CALL, 8'h00, rpc, 4'h0, 1'b0, 8'h00, 1, tag);
  endtask

  task automatic do_ret(input string tag);
    logic [7:0] d; logic b;
    m_pop(d, b);
    if (!b) exp_rd.push_back(d);
    issue(OP_RET, 8'h00, 8'h00, 4'h0, 1'b0, 8'h00, 2, tag);
  endtask

  task automatic do_int(input logic [7:0] rpc, input logic [3:0] fl, input string tag);
    m_push(rpc);
    m_push({4'h0, fl});
    issue(OP_INT, 8'h00, rpc, fl, 1'b0, 8'h00, 2, tag);
  endtask

  task automatic do_rti(input string tag);
    logic [7:0] d; logic b;
    m_pop(d, b);
    if (!b) exp_rd.push_back({4'h0, d[3:0]});
    m_pop(d, b);
    if (!b) exp_rd.push_back(d);
    issue(OP_RTI, 8'h00, 8'h00, 4'h0, 1'b0, 8'h00, 3, tag);
  endtask

  task automatic load_sp(input logic [7:0] v, input string tag);
    @(posedge clk); #1;
    bus.sp_load = 1'b1; bus.sp_load_val = v;
    @(negedge clk);
    chk({tag, "_wb_en"}, 32'(bus.sp_wb_en), 1);
    chk({tag, "_wb_val"}, bus.sp_out, v);
    @(posedge clk); #1;
    bus.sp_load = 1'b0;
    sp_m = v;
    @(negedge clk);
    chk({tag, "_wb_idle"}, 32'(bus.sp_wb_en), 0);
    chk({tag, "_sp"}, bus.sp_out, v);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.op_valid = 1'b0; bus.op_code = OP_NONE; bus.wr_data = '0; bus.ret_pc = '0;
    bus.flags_in = '0; bus.sp_load = 1'b0; bus.sp_load_val = '0;
    sp_m = 8'hFF; ovf_m = 1'b0; unf_m = 1'b0;

    @(negedge clk);
    chk("rst_sp", bus.sp_out, 8'hFF);
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_we", 32'(bus.mem_we), 0);
    chk("rst_pop_data", bus.pop_data, 8'h00);
    chk("rst_pc_target", bus.pc_target, 8'h00);
    chk("rst_flags_out", bus.flags_out, 4'h0);
    chk("rst_errs", {bus.err_ovf, bus.err_unf}, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;

    do_push(8'hAA, 1'b0, 8'h00, "push_aa");
    chk("push_aa_wb_en", 32'(wb0), 1);
    chk("push_aa_wb_val", spo0, 8'hFE);
    chk("push_aa_mem", mem[8'hFF], 8'hAA);
    do_pop("pop_aa");
    do_push(8'hCC, 1'b0, 8'h00, "push_cc");
    do_pop("pop_cc");
    chk("pop_hold", bus.pop_data, 8'hCC);

    do_call(8'h06, "call");
    chk("call_mem", mem[8'hFF], 8'h06);
    do_ret("ret");

    do_int(8'h20, 4'hA, "int");
    chk("int_mem_ff", mem[8'hFF], 8'h20);
    chk("int_mem_fe", mem[8'hFE], 8'h0A);
    do_rti("rti");
    do_push(8'h5A, 1'b0, 8'h00, "push_after_rti");
    chk("flags_hold", bus.flags_out, 4'hA);
    chk("pc_hold", bus.pc_target, 8'h20);
    do_pop("pop_5a");

    load_sp(8'h40, "load40");
    do_push(8'h11, 1'b0, 8'h00, "push_at_40");
    do_push(8'h55, 1'b1, 8'h10, "push_load10");
    chk("push_load10_mem", mem[8'h10], 8'h55);

    load_sp(8'h00, "load00");
    do_push(8'h77, 1'b0, 8'h00, "push_at_00");
    chk("err_ovf", 32'(bus.err_ovf), 32'(ovf_m));
    load_sp(8'hFF, "loadff");
    do_pop("pop_at_ff");
    chk("err_unf", 32'(bus.err_unf), 32'(unf_m));

    // Reset while the INT sequence is in its flags phase.
    load_sp(8'hFF, "loadff2");
    @(posedge clk); #1;
    cur_op = OP_INT;
    bus.op_valid = 1'b1; bus.op_code = OP_INT; bus.ret_pc = 8'h33; bus.flags_in = 4'h5;
    exp_wr.push_back({8'hFF, 8'h33});
    @(negedge clk);
    chk("int_abort_busy_t", 32'(bus.busy), 1);
    @(posedge clk); #1;
    bus.op_valid = 1'b0; bus.op_code = OP_NONE;
    rst_n = 1'b0;
    #1;
    chk("int_abort_sp", bus.sp_out, 8'hFF);
    chk("int_abort_busy", 32'(bus.busy), 0);
    chk("int_abort_we", 32'(bus.mem_we), 0);
    @(negedge clk);
    chk("int_abort_mem_ff", mem[8'hFF], 8'h33);
    chk("int_abort_mem_fe", mem[8'hFE], 8'h0A);
    chk("int_abort_wr_pending", 32'(exp_wr.size()), 0);
    chk("int_abort_errs", {bus.err_ovf, bus.err_unf}, 2'b00);
    @(posedge clk); #1;
    rst_n = 1'b1;
    sp_m = 8'hFF; ovf_m = 1'b0; unf_m = 1'b0;
    mm[8'hFF] = 8'h33;
    do_push(8'h99, 1'b0, 8'h00, "push_after_abort");
    do_pop("pop_after_abort");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
